// File: rtl/multiplier.sv
// Two-stage 32x32 -> 64 multiplier for MULT/MULTU: radix-4 Booth + Wallace CSA tree,
// then a registered sum/carry pair resolved by a single carry-propagate adder.

// One Wallace level: every full group of three rows becomes a (sum, carry) pair,
// and leftover rows pass straight through to the next level.
module multiplier_csa_level #(
  parameter int N_IN = 3
) (
  input  logic [63:0] rows_in  [N_IN],
  output logic [63:0] rows_out [2*(N_IN/3) + N_IN%3]
);
  localparam int N_GRP = N_IN / 3;
  localparam int N_REM = N_IN % 3;

  genvar gi;
  generate
    for (gi = 0; gi < N_GRP; gi++) begin : g_csa
      assign rows_out[2*gi]   = rows_in[3*gi] ^ rows_in[3*gi+1] ^ rows_in[3*gi+2];
      assign rows_out[2*gi+1] = ((rows_in[3*gi] & rows_in[3*gi+1]) |
                                 (rows_in[3*gi] & rows_in[3*gi+2]) |
                                 (rows_in[3*gi+1] & rows_in[3*gi+2])) << 1;
    end
    for (gi = 0; gi < N_REM; gi++) begin : g_pass
      assign rows_out[2*N_GRP + gi] = rows_in[3*N_GRP + gi];
    end
  endgenerate
endmodule

module multiplier (
  input  logic        clock,
  input  logic        reset,
  input  logic        is_signed,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  output logic [63:0] result
);
  logic        x_ext;
  logic        y_ext;
  logic [63:0] x64;
  logic [34:0] ybits;

  assign x_ext = is_signed & input1[31];
  assign y_ext = is_signed & input2[31];
  assign x64   = {{31{x_ext}}, x_ext, input1};
  // Extended multiplier sign-duplicated once more so group 16 sees bits {33,32,31}.
  assign ybits = {y_ext, y_ext, input2, 1'b0};

  logic [63:0] lvl0 [17];
  logic [63:0] lvl1 [12];
  logic [63:0] lvl2 [8];
  logic [63:0] lvl3 [6];
  logic [63:0] lvl4 [4];
  logic [63:0] lvl5 [3];
  logic [63:0] lvl6 [2];

  genvar gi;
  generate
    for (gi = 0; gi < 17; gi++) begin : g_booth
      logic [2:0]  grp;
      logic [63:0] mag;
      logic        neg;
      logic [63:0] pp;

      assign grp = ybits[2*gi+2 -: 3];

      always_comb begin
        mag = 64'd0;
        neg = 1'b0;
        case (grp)
          3'b001, 3'b010: mag = x64;
          3'b011:         mag = x64 << 1;
          3'b100: begin
            mag = x64 << 1;
            neg = 1'b1;
          end
          3'b101, 3'b110: begin
            mag = x64;
            neg = 1'b1;
          end
          default: mag = 64'd0;
        endcase
        pp = neg ? (~mag + 64'd1) : mag;
      end

      assign lvl0[gi] = pp << (2*gi);
    end
  endgenerate

  multiplier_csa_level #(.N_IN(17)) u_lvl1 (.rows_in(lvl0), .rows_out(lvl1));
  multiplier_csa_level #(.N_IN(12)) u_lvl2 (.rows_in(lvl1), .rows_out(lvl2));
  multiplier_csa_level #(.N_IN(8))  u_lvl3 (.rows_in(lvl2), .rows_out(lvl3));
  multiplier_csa_level #(.N_IN(6))  u_lvl4 (.rows_in(lvl3), .rows_out(lvl4));
  multiplier_csa_level #(.N_IN(4))  u_lvl5 (.rows_in(lvl4), .rows_out(lvl5));
  multiplier_csa_level #(.N_IN(3))  u_lvl6 (.rows_in(lvl5), .rows_out(lvl6));

  logic [63:0] sum_next;
  logic [63:0] carry_next;
  logic [63:0] sum_reg;
  logic [63:0] carry_reg;

  assign sum_next   = lvl6[0];
  assign carry_next = lvl6[1];

  // The datapath loads on every edge, reset included, so the product captured on
  // the last reset-high edge is already visible in the first cycle after reset.
  always_ff @(posedge clock) begin
    sum_reg   <= sum_next;
    carry_reg <= carry_next;
  end

  logic unused_reset;
  assign unused_reset = reset;

  assign result = sum_reg + carry_reg;
endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for multiplier: the driver queues one expected product per edge,
// the monitor pops and compares one entry after each rising edge.
module tb_multiplier;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        is_signed = 1'b0;
  logic [31:0] input1 = 32'd0;
  logic [31:0] input2 = 32'd0;
  logic [63:0] result;

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  string       name_q[$];

  multiplier dut (
    .clock(clock),
    .reset(reset),
    .is_signed(is_signed),
    .input1(input1),
    .input2(input2),
    .result(result)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // Drive one operation for the coming rising edge and queue its expected product.
  task automatic apply(input string nm, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp);
    @(negedge clock);
    is_signed = s;
    input1    = a;
    input2    = b;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    $display("issue %-14s s=%0d a=%h b=%h exp=%h", nm, s, a, b, exp);
  endtask

  // Monitor: each edge's captured operands show up on result right after that edge.
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [63:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (result !== e) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", n, result, e);
      end else begin
        $display("ok   %-14s result=%h", n, result);
      end
    end
  end

  initial begin
    // Zero operands while in reset: the register loads anyway.
    apply("reset_zero",   1'b0, 32'h0000_0000, 32'h0000_0000, 64'h0);
    apply("reset_zero2",  1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 64'h0);
    // Last reset-high edge captures 0x10000*0x10000.
    apply("reset_transp", 1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    @(negedge clock);
    reset = 1'b0;
    is_signed = 1'b1;
    input1 = 32'h8000_0000;
    input2 = 32'h8000_0000;
    exp_q.push_back(64'h4000_0000_0000_0000);
    name_q.push_back("min_signed");
    $display("issue %-14s s=1 a=80000000 b=80000000 exp=4000000000000000", "min_signed");

    apply("min_unsigned", 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    apply("ones_signed",  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    apply("ones_unsigned",1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    apply("mixed_signed", 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA);
    apply("mixed_unsign", 1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 64'h0000_0002_FFFF_FFFA);
    apply("b2b_7x6",      1'b0, 32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002A);
    apply("b2b_x0",       1'b1, 32'h1234_5678, 32'h0000_0000, 64'h0);
    apply("min_x_m1_s",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    apply("min_x_m1_u",   1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h7FFF_FFFF_8000_0000);
    apply("max_x_min_s",  1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    apply("one_x_m1_s",   1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    apply("top_group_u",  1'b0, 32'h0000_0003, 32'h8000_0000, 64'h0000_0001_8000_0000);
    apply("top_group_s",  1'b1, 32'h0000_0003, 32'h8000_0000, 64'hFFFF_FFFE_8000_0000);

    for (int i = 0; i < 10000; i++) begin
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      if (failures > 0) break;
      s = 1'($urandom_range(1, 0));
      a = $urandom;
      b = $urandom;
      @(negedge clock);
      is_signed = s;
      input1 = a;
      input2 = b;
      exp_q.push_back(ref_mul(s, a, b));
      name_q.push_back("soak");
    end

    @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
